// File: rtl/flag_branch_unit.sv
// Flag register with per-opcode update masking and a conditional-branch resolver.
// A taken branch issues a one-cycle redirect pulse and a two-cycle flush of younger stages.
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic        alu_zr,
    input  logic        alu_ov,
    input  logic        alu_neg,
    input  logic        flag_we,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_target,
    input  logic [15:0] pc_plus1,
    input  logic        stall,
    output logic        zr_q,
    output logic        ov_q,
    output logic        neg_q,
    output logic        br_taken,
    output logic [15:0] br_pc,
    output logic        flush
);

    logic        r_zr;
    logic        r_ov;
    logic        r_neg;
    logic        r_taken;
    logic [15:0] r_pc;
    logic [1:0]  r_fcnt;

    logic        w_upd;
    logic        w_arith;
    logic        w_logic;
    logic        w_zr;
    logic        w_ov;
    logic        w_neg;
    logic        w_cond;
    logic        w_accept;
    logic        w_take;
    logic [15:0] w_pc;
    logic [1:0]  w_fcnt;

    always_comb begin
        w_upd   = flag_we & ~stall;
        w_arith = (alu_op <= 4'h2);
        w_logic = (alu_op[3:2] == 2'b01);

        // Next-state flags double as the bypass source for the branch condition.
        w_zr  = (w_upd & (w_arith | w_logic)) ? alu_zr  : r_zr;
        w_ov  = (w_upd & w_arith)             ? alu_ov  : r_ov;
        w_neg = (w_upd & w_arith)             ? alu_neg : r_neg;

        w_cond = 1'b0;
        unique case (br_cond)
            3'b000: w_cond = ~w_zr;
            3'b001: w_cond = w_zr;
            3'b010: w_cond = ~w_zr & ~w_neg;
            3'b011: w_cond = w_neg;
            3'b100: w_cond = w_zr | ~w_neg;
            3'b101: w_cond = w_neg | w_zr;
            3'b110: w_cond = w_ov;
            3'b111: w_cond = 1'b1;
        endcase

        // Branches seen while flushing are wrong-path and are dropped.
        w_accept = br_valid & ~stall & (r_fcnt == 2'd0);
        w_take   = w_accept & w_cond;

        w_pc = r_pc;
        if (w_accept) begin
            w_pc = w_cond ? br_target : pc_plus1;
        end

        if (w_take) begin
            w_fcnt = 2'd2;
        end else if (r_fcnt != 2'd0) begin
            w_fcnt = r_fcnt - 2'd1;
        end else begin
            w_fcnt = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zr    <= 1'b0;
            r_ov    <= 1'b0;
            r_neg   <= 1'b0;
            r_taken <= 1'b0;
            r_pc    <= 16'h0000;
            r_fcnt  <= 2'd0;
        end else if (!stall) begin
            r_zr    <= w_zr;
            r_ov    <= w_ov;
            r_neg   <= w_neg;
            r_taken <= w_take;
            r_pc    <= w_pc;
            r_fcnt  <= w_fcnt;
        end
    end

    assign zr_q     = r_zr;
    assign ov_q     = r_ov;
    assign neg_q    = r_neg;
    assign br_taken = r_taken;
    assign br_pc    = r_pc;
    assign flush    = (r_fcnt != 2'd0);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios then randomized traffic,
// compared cycle by cycle against a behavioural model of the flag/branch rules.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic        alu_zr, alu_ov, alu_neg;
    logic        flag_we;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target, pc_plus1;
    logic        stall;
    logic        zr_q, ov_q, neg_q;
    logic        br_taken;
    logic [15:0] br_pc;
    logic        flush;

    flag_branch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .alu_op    (alu_op),
        .alu_zr    (alu_zr),
        .alu_ov    (alu_ov),
        .alu_neg   (alu_neg),
        .flag_we   (flag_we),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_target (br_target),
        .pc_plus1  (pc_plus1),
        .stall     (stall),
        .zr_q      (zr_q),
        .ov_q      (ov_q),
        .neg_q     (neg_q),
        .br_taken  (br_taken),
        .br_pc     (br_pc),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    bit      m_z, m_v, m_n, m_taken;
    bit [15:0] m_pc;
    int      m_flush_left;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit cond_holds(input int c, input bit z, input bit v, input bit n);
        case (c)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || !n;
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_edge();
        int  op;
        bit  upd;
        bit  take;
        op = int'(alu_op);
        if (rst) begin
            {m_z, m_v, m_n, m_taken} = 4'b0;
            m_pc = 16'h0000;
            m_flush_left = 0;
        end else if (!stall) begin
            upd = flag_we;
            if (upd && op <= 2) begin
                m_z = alu_zr; m_v = alu_ov; m_n = alu_neg;
            end else if (upd && op >= 4 && op <= 7) begin
                m_z = alu_zr;
            end
            take = 1'b0;
            if (br_valid && m_flush_left == 0) begin
                take = cond_holds(int'(br_cond), m_z, m_v, m_n);
                m_pc = take ? br_target : pc_plus1;
            end
            m_taken = take;
            if (take) m_flush_left = 2;
            else if (m_flush_left > 0) m_flush_left--;
        end
    endtask

    task automatic check_all();
        check("zr_q", 16'(zr_q), 16'(m_z));
        check("ov_q", 16'(ov_q), 16'(m_v));
        check("neg_q", 16'(neg_q), 16'(m_n));
        check("br_taken", 16'(br_taken), 16'(m_taken));
        check("br_pc", br_pc, m_pc);
        check("flush", 16'(flush), 16'(m_flush_left != 0));
    endtask

    task automatic step(input bit r, input bit st, input bit we, input logic [3:0] op,
                        input bit z, input bit v, input bit n, input bit bv,
                        input logic [2:0] c, input logic [15:0] tgt, input logic [15:0] p1);
        rst = r; stall = st; flag_we = we; alu_op = op;
        alu_zr = z; alu_ov = v; alu_neg = n;
        br_valid = bv; br_cond = c; br_target = tgt; pc_plus1 = p1;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 4'hF, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    endtask

    initial begin
        // Reset from unknown state
        step(1, 0, 0, 4'h0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        check("reset_pc", br_pc, 16'h0000);

        // Reset with flags set and flush counter at 2
        step(0, 0, 1, 4'h0, 1, 1, 1, 0, 3'd0, 16'h0, 16'h0);
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h5555, 16'h0001);
        check("pre_reset_flush", 16'(flush), 16'h1);
        step(1, 1, 1, 4'h0, 1, 1, 1, 1, 3'd7, 16'h7777, 16'h0002);
        check("rst_flush", 16'(flush), 16'h0);
        check("rst_pc", br_pc, 16'h0000);
        check("rst_zr", 16'(zr_q), 16'h0);

        // Flag masking: logic op touches only Z
        step(0, 0, 1, 4'h0, 0, 1, 1, 0, 3'd0, 16'h0, 16'h0);
        step(0, 0, 1, 4'h4, 1, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        check("mask_flags", 16'({zr_q, ov_q, neg_q}), 16'b111);
        // Non-updating opcodes
        step(0, 0, 1, 4'h3, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        step(0, 0, 1, 4'hA, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        check("noupd_flags", 16'({zr_q, ov_q, neg_q}), 16'b111);

        // Bypass: flag write and EQ branch in the same cycle
        step(0, 0, 1, 4'h0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        step(0, 0, 1, 4'h2, 1, 0, 0, 1, 3'd1, 16'h1234, 16'h0099);
        check("bypass_taken", 16'(br_taken), 16'h1);
        check("bypass_pc", br_pc, 16'h1234);
        idle();
        check("bypass_flush2", 16'(flush), 16'h1);
        idle();
        check("bypass_flush_end", 16'(flush), 16'h0);

        // Not taken: NE with Z=1
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd0, 16'h8888, 16'h0041);
        check("nt_taken", 16'(br_taken), 16'h0);
        check("nt_pc", br_pc, 16'h0041);
        check("nt_flush", 16'(flush), 16'h0);

        // Wrong-path drop during both flush cycles
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h2000, 16'h0100);
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h3000, 16'h0200);
        check("wp1_taken", 16'(br_taken), 16'h0);
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h3000, 16'h0200);
        check("wp2_pc", br_pc, 16'h2000);
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h3000, 16'h0200);
        check("wp_after_pc", br_pc, 16'h3000);
        idle(); idle();

        // Stall in the middle of a flush, flag writes ignored under stall
        step(0, 0, 0, 4'hF, 0, 0, 0, 1, 3'd7, 16'h4000, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 4'h0, 0, 1, 0, 1, 3'd7, 16'h5000, 16'h0400);
            check("stall_flush", 16'(flush), 16'h1);
        end
        check("stall_flags", 16'(zr_q), 16'h1);
        idle();
        check("post_stall_flush", 16'(flush), 16'h1);
        idle();
        check("post_stall_done", 16'(flush), 16'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, 3'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: alu_op  input  4  opcode of the instruction whose ALU flags are presented this cycle.
REQ-004 SHALL have port: alu_zr, alu_ov, alu_neg  input  1 each  zero/overflow/negative flags from the ALU.
REQ-005 SHALL have port: flag_we  input  1  ALU flags valid this cycle; instruction is committing.
REQ-006 SHALL have port: br_valid  input  1  conditional branch present in resolve stage.
REQ-007 SHALL have port: br_cond  input  3  branch condition code.
REQ-008 SHALL have port: br_target, pc_plus1  input  16 each  taken and fall-through addresses.
REQ-009 SHALL have port: stall  input  1  pipeline freeze.
REQ-010 SHALL have port: zr_q, ov_q, neg_q  output  1 each  architectural flag register.
REQ-011 SHALL have port: br_taken  output  1  registered one-cycle taken pulse.
REQ-012 SHALL have port: br_pc  output  16  registered redirect address.
REQ-013 SHALL have port: flush  output  1  squash younger fetch/decode stages.

Function
REQ-014 SHALL update flags only on rising clk with flag_we=1, stall=0, rst=0.
REQ-015 SHALL treat alu_op 0x0-0x2 (arithmetic) as updating Z, V, N from alu_zr/alu_ov/alu_neg.
REQ-016 SHALL treat alu_op 0x4-0x7 (logic, shift) as updating Z only; V, N hold.
REQ-017 SHALL treat alu_op 0x3 and 0x8-0xF as no flag update, even with flag_we=1.
REQ-018 SHALL evaluate the condition with bypassed flags: next-state Z/V/N when a REQ-014 update occurs in the same cycle, otherwise the registered flags.
REQ-019 SHALL decode br_cond: 000 NE (Z=0); 001 EQ (Z=1); 010 GT (Z=0 and N=0); 011 LT (N=1); 100 GE (Z=1 or N=0); 101 LE (N=1 or Z=1); 110 OV (V=1); 111 always.
REQ-020 SHALL accept a branch when br_valid=1, stall=0, and the flush counter is zero. Rejected branches have no effect.
REQ-021 SHALL, for an accepted branch sampled at edge k, drive br_taken=condition and br_pc=(taken ? br_target : pc_plus1) during cycle k+1. These are 1-cycle latency registered outputs.
REQ-022 SHALL hold br_pc between accepted branches. br_taken SHALL return to 0 one cycle after any pulse unless stall=1.
REQ-023 SHALL keep a 2-bit flush counter. A taken branch loads 2, and the counter decrements by one per unstalled cycle down to 0. flush=1 when the counter is nonzero, so flush is high exactly in cycles k+1 and k+2.
REQ-024 SHALL ignore br_valid while flush=1, because that branch is a wrong-path instruction. Flag updates with flag_we=1 SHALL still proceed during flush.
REQ-025 SHALL freeze all state while stall=1: flags, br_taken, br_pc and the flush counter hold.
REQ-026 SHALL let rst take priority over stall, flag_we and br_valid in the same cycle.

Reset
REQ-027 SHALL on rst clear zr_q, ov_q, neg_q, br_taken, flush and the flush counter to 0, and set br_pc to 0x0000.
REQ-028 SHALL abort an in-progress flush on rst: flush=0 the cycle after the rst edge.

Verification
REQ-029 Reset: flags set to 1, counter=2, rst=1 for one edge -> all outputs 0 the next cycle, br_pc=0x0000.
REQ-030 Flag masking: alu_op=0x0 with Z,V,N=0,1,1, flag_we=1, then alu_op=0x4 with Z,V,N=1,0,0 -> after the second edge, zr_q=1, ov_q=1, neg_q=1.
REQ-031 Bypass: alu_op=0x2 with alu_zr=1, flag_we=1, and in the same cycle br_valid=1, br_cond=001, target 0x1234 -> next cycle br_taken=1, br_pc=0x1234, and flush=1 for 2 cycles.
REQ-032 Not taken: Z=1 registered, br_cond=000, pc_plus1=0x0041 -> br_taken=0, br_pc=0x0041, flush stays 0.
REQ-033 Wrong-path drop: taken branch, then br_valid=1, br_cond=111 during both flush cycles -> no second br_taken and br_pc unchanged. A branch issued once flush=0 is accepted.
REQ-034 Stall: stall=1 for 3 cycles in the middle of a flush -> flush stays 1 and the counter holds. Flush then completes its remaining cycle after stall drops. flag_we under stall leaves the flags unchanged.
